uart_16550_tx_engine: RTL and testbench

//  Parametrised 16550-compatible transmit path: TX holding FIFO, x16 baud prescaler from a divisor latch,
//  and a serialiser supporting 5-8 data bits, optional/stick parity, 1/1.5/2 stop bits and break.

---
 rtl/uart_16550_tx_engine.sv | 211 +++++++++++++++++++++
 tb/tb_uart_16550_tx_engine.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_16550_tx_engine.sv
// 16550-style transmit path: TX holding FIFO, x16 baud prescaler and a 5-8 bit serialiser
// with optional/stick parity, 1/1.5/2 stop bits and break.
module uart_16550_tx_engine #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  input  logic                          fifo_clr,
  input  logic [DIV_WIDTH-1:0]          divisor,
  input  logic [1:0]                    lcr_wls,
  input  logic                          lcr_stb,
  input  logic                          lcr_pen,
  input  logic                          lcr_eps,
  input  logic                          lcr_sp,
  input  logic                          lcr_bc,
  output logic                          txd,
  output logic                          thre,
  output logic                          temt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          wr_overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(2 * OVERSAMPLE) > 0 ? $clog2(2 * OVERSAMPLE) : 1;

  localparam logic [TW-1:0] BitLast    = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] Stop15Last = TW'((3 * OVERSAMPLE) / 2 - 1);
  localparam logic [TW-1:0] Stop2Last  = TW'(2 * OVERSAMPLE - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e               state_q, state_d;
  logic [7:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [DIV_WIDTH-1:0] presc_q, presc_d, div_q, div_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           shreg_q, shreg_d;
  logic [1:0]           wls_q, wls_d;
  logic                 stb_q, stb_d, pen_q, pen_d, eps_q, eps_d, sp_q, sp_d;
  logic                 txd_q, txd_d, thre_q, thre_d, temt_q, temt_d, ovf_q, ovf_d;

  logic          full, push, pop, pop_ok, tick, bit_end, level, parity;
  logic [TW-1:0] stop_last, bit_last;
  logic [2:0]    nbits_last;
  logic [7:0]    data_mask;

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    presc_d = presc_q;
    div_d   = div_q;
    tcnt_d  = tcnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    wls_d   = wls_q;
    stb_d   = stb_q;
    pen_d   = pen_q;
    eps_d   = eps_q;
    sp_d    = sp_q;
    pop     = 1'b0;

    // Space is judged on the registered count only; a same-cycle pop does not make room.
    full   = (count_q == CW'(FIFO_DEPTH));
    push   = wr_en && !fifo_clr && !full;
    ovf_d  = wr_en && !fifo_clr && full;
    pop_ok = (count_q != '0) && (divisor != '0);

    // The working divisor is only reloaded at a prescaler wrap (or pop), so changes land cleanly.
    tick = (div_q != '0) && (presc_q == div_q - DIV_WIDTH'(1));
    if ((div_q == '0) || tick) begin
      presc_d = '0;
      div_d   = divisor;
    end else begin
      presc_d = presc_q + DIV_WIDTH'(1);
    end

    stop_last  = !stb_q ? BitLast : ((wls_q == 2'd0) ? Stop15Last : Stop2Last);
    bit_last   = (state_q == StStop) ? stop_last : BitLast;
    bit_end    = tick && (tcnt_q == bit_last);
    nbits_last = 3'(wls_q) + 3'd4;
    if (tick) begin
      tcnt_d = bit_end ? '0 : tcnt_q + TW'(1);
    end

    case (state_q)
      StIdle: begin
        if (pop_ok) pop = 1'b1;
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          bit_d   = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_q == nbits_last) state_d = pen_q ? StParity : StStop;
          else                     bit_d   = bit_q + 3'd1;
        end
      end
      StParity: begin
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        if (bit_end) begin
          if (pop_ok) pop = 1'b1;
          else        state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Popping restarts bit timing and snapshots the line settings for the whole frame.
    if (pop) begin
      state_d = StStart;
      shreg_d = mem[rptr_q];
      rptr_d  = rptr_q + AW'(1);
      wls_d   = lcr_wls;
      stb_d   = lcr_stb;
      pen_d   = lcr_pen;
      eps_d   = lcr_eps;
      sp_d    = lcr_sp;
      presc_d = '0;
      div_d   = divisor;
      tcnt_d  = '0;
      bit_d   = '0;
    end

    if (push) wptr_d = wptr_q + AW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
    if (fifo_clr) begin
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end

    thre_d = (count_d == '0);
    temt_d = thre_d && (state_d == StIdle);

    data_mask = 8'hFF >> (2'd3 - wls_d);
    parity    = sp_d ? ~eps_d : ((^(shreg_d & data_mask)) ^ ~eps_d);
    case (state_d)
      StStart:  level = 1'b0;
      StData:   level = shreg_d[bit_d];
      StParity: level = parity;
      default:  level = 1'b1;
    endcase
    txd_d = lcr_bc ? 1'b0 : level;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      presc_q <= '0;
      div_q   <= '0;
      tcnt_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      wls_q   <= '0;
      stb_q   <= 1'b0;
      pen_q   <= 1'b0;
      eps_q   <= 1'b0;
      sp_q    <= 1'b0;
      txd_q   <= 1'b1;
      thre_q  <= 1'b1;
      temt_q  <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      presc_q <= presc_d;
      div_q   <= div_d;
      tcnt_q  <= tcnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      wls_q   <= wls_d;
      stb_q   <= stb_d;
      pen_q   <= pen_d;
      eps_q   <= eps_d;
      sp_q    <= sp_d;
      txd_q   <= txd_d;
      thre_q  <= thre_d;
      temt_q  <= temt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign txd         = txd_q;
  assign thre        = thre_q;
  assign temt        = temt_q;
  assign fifo_count  = count_q;
  assign wr_overflow = ovf_q;

endmodule

// File: tb/tb_uart_16550_tx_engine.sv
// Directed bench for uart_16550_tx_engine: frame shapes, FIFO limits, flush, break and reset.
module tb_uart_16550_tx_engine;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        fifo_clr;
  logic [15:0] divisor;
  logic [1:0]  lcr_wls;
  logic        lcr_stb, lcr_pen, lcr_eps, lcr_sp, lcr_bc;
  logic        txd, thre, temt, wr_overflow;
  logic [4:0]  fifo_count;

  int n_tests = 0;
  int n_fail  = 0;

  uart_16550_tx_engine #(
    .FIFO_DEPTH(16),
    .DIV_WIDTH (16),
    .OVERSAMPLE(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .fifo_clr   (fifo_clr),
    .divisor    (divisor),
    .lcr_wls    (lcr_wls),
    .lcr_stb    (lcr_stb),
    .lcr_pen    (lcr_pen),
    .lcr_eps    (lcr_eps),
    .lcr_sp     (lcr_sp),
    .lcr_bc     (lcr_bc),
    .txd        (txd),
    .thre       (thre),
    .temt       (temt),
    .fifo_count (fifo_count),
    .wr_overflow(wr_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Write one byte; returns at the first negedge of its start bit (queue assumed empty, idle).
  task automatic send(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    wait_n(1);
    wr_en   = 1'b0;
    wait_n(1);
  endtask

  // Called at the first cycle of the start bit; checks first/last cycle of every bit.
  task automatic frame(input logic [11:0] lv, input int nb, input int blen, input int slen,
                       input string tag);
    for (int b = 0; b < nb; b++) begin
      chk($sformatf("%s bit%0d first", tag, b), 32'(txd), 32'(lv[b]));
      wait_n(blen - 1);
      chk($sformatf("%s bit%0d last", tag, b), 32'(txd), 32'(lv[b]));
      wait_n(1);
    end
    chk($sformatf("%s stop first", tag), 32'(txd), 32'd1);
    wait_n(slen - 1);
    chk($sformatf("%s stop last", tag), 32'(txd), 32'd1);
    chk($sformatf("%s temt in stop", tag), 32'(temt), 32'd0);
    wait_n(1);
  endtask

  initial begin
    logic [7:0] d;
    logic       bad;
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; fifo_clr = 1'b0; divisor = 16'd1;
    lcr_wls = 2'd3; lcr_stb = 1'b0; lcr_pen = 1'b0; lcr_eps = 1'b0; lcr_sp = 1'b0;
    lcr_bc = 1'b0;
    wait_n(3);
    rst = 1'b0;
    chk("reset txd", 32'(txd), 32'd1);
    chk("reset thre", 32'(thre), 32'd1);
    chk("reset temt", 32'(temt), 32'd1);
    chk("reset count", 32'(fifo_count), 32'd0);
    chk("reset ovf", 32'(wr_overflow), 32'd0);

    // 8N1, div 1, 0x55
    wr_en = 1'b1; wr_data = 8'h55;
    wait_n(1);
    wr_en = 1'b0;
    chk("t1 count after write", 32'(fifo_count), 32'd1);
    chk("t1 thre after write", 32'(thre), 32'd0);
    chk("t1 txd before pop", 32'(txd), 32'd1);
    wait_n(1);
    chk("t1 thre after pop", 32'(thre), 32'd1);
    chk("t1 temt after pop", 32'(temt), 32'd0);
    frame(12'h0AA, 9, 16, 16, "t1");
    chk("t1 temt end", 32'(temt), 32'd1);
    chk("t1 txd end", 32'(txd), 32'd1);

    // 7 bits, even parity, 2 stop, div 2
    divisor = 16'd2; lcr_wls = 2'd2; lcr_pen = 1'b1; lcr_eps = 1'b1; lcr_stb = 1'b1;
    send(8'h03);
    frame(12'h006, 9, 32, 64, "t2");
    chk("t2 temt end", 32'(temt), 32'd1);

    // 5 bits, 1.5 stop, div 1
    divisor = 16'd1; lcr_wls = 2'd0; lcr_pen = 1'b0; lcr_eps = 1'b0; lcr_stb = 1'b1;
    send(8'h1F);
    frame(12'h03E, 6, 16, 24, "t3");
    chk("t3 temt end", 32'(temt), 32'd1);

    // Fill while halted, overflow, then drain back-to-back
    lcr_wls = 2'd3; lcr_stb = 1'b0;
    divisor = 16'd0;
    wait_n(2);
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; wr_data = 8'(i * 37 + 5);
      wait_n(1);
    end
    wr_en = 1'b0;
    chk("t4 count full", 32'(fifo_count), 32'd16);
    chk("t4 ovf pulse", 32'(wr_overflow), 32'd1);
    chk("t4 txd halted", 32'(txd), 32'd1);
    wait_n(1);
    chk("t4 ovf cleared", 32'(wr_overflow), 32'd0);
    divisor = 16'd1;
    wait_n(1);
    for (int i = 0; i < 16; i++) begin
      d = 8'(i * 37 + 5);
      chk($sformatf("t4 f%0d count", i), 32'(fifo_count), 32'(15 - i));
      chk($sformatf("t4 f%0d thre", i), 32'(thre), (i == 15) ? 32'd1 : 32'd0);
      frame({3'b000, d, 1'b0}, 9, 16, 16, $sformatf("t4 f%0d", i));
    end
    chk("t4 temt end", 32'(temt), 32'd1);

    // Flush during first of three queued frames
    wr_en = 1'b1; wr_data = 8'hC3;
    wait_n(1);
    wr_data = 8'h11;
    wait_n(1);
    wr_data = 8'h22;
    chk("t5 start", 32'(txd), 32'd0);
    wait_n(1);
    wr_en = 1'b0;
    chk("t5 count queued", 32'(fifo_count), 32'd2);
    fifo_clr = 1'b1;
    wait_n(1);
    fifo_clr = 1'b0;
    chk("t5 thre after clr", 32'(thre), 32'd1);
    chk("t5 count after clr", 32'(fifo_count), 32'd0);
    chk("t5 temt busy", 32'(temt), 32'd0);
    wait_n(22);
    chk("t5 data bit0", 32'(txd), 32'd1);
    wait_n(135);
    chk("t5 stop last", 32'(txd), 32'd1);
    chk("t5 temt in stop", 32'(temt), 32'd0);
    wait_n(1);
    chk("t5 temt end", 32'(temt), 32'd1);
    bad = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (txd !== 1'b1 || temt !== 1'b1) bad = 1'b1;
      wait_n(1);
    end
    chk("t5 no further frames", 32'(bad), 32'd0);

    // Break asserted mid-data
    send(8'hFF);
    wait_n(18);
    lcr_bc = 1'b1;
    wait_n(1);
    chk("t6 break low", 32'(txd), 32'd0);
    wait_n(19);
    chk("t6 break held", 32'(txd), 32'd0);
    lcr_bc = 1'b0;
    wait_n(1);
    chk("t6 resume level", 32'(txd), 32'd1);
    wait_n(120);
    chk("t6 stop last", 32'(txd), 32'd1);
    chk("t6 temt in stop", 32'(temt), 32'd0);
    wait_n(1);
    chk("t6 temt end", 32'(temt), 32'd1);

    // Reset mid-frame with one byte still queued
    wr_en = 1'b1; wr_data = 8'h00;
    wait_n(1);
    wait_n(1);
    wr_en = 1'b0;
    wait_n(28);
    chk("t7 data low", 32'(txd), 32'd0);
    chk("t7 count queued", 32'(fifo_count), 32'd1);
    rst = 1'b1;
    wait_n(1);
    rst = 1'b0;
    chk("t7 txd", 32'(txd), 32'd1);
    chk("t7 thre", 32'(thre), 32'd1);
    chk("t7 temt", 32'(temt), 32'd1);
    chk("t7 count", 32'(fifo_count), 32'd0);
    wait_n(50);
    chk("t7 stays idle txd", 32'(txd), 32'd1);
    chk("t7 stays idle temt", 32'(temt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
